// File: rtl/regdst_pkg.sv
// Shared constants for the register-destination select and scoreboard block:
// destination-select codes and sticky error bit positions.
package regdst_pkg;
  localparam logic [2:0] SEL_RT = 3'b000;
  localparam logic [2:0] SEL_RD = 3'b001;
  localparam logic [2:0] SEL_SP = 3'b010;
  localparam logic [2:0] SEL_RA = 3'b011;
  localparam logic [2:0] SEL_X4 = 3'b100;
  localparam logic [2:0] SEL_X5 = 3'b101;

  localparam int ERR_W       = 2;
  localparam int ERR_ILL_SEL = 0;
  localparam int ERR_WB_MISS = 1;
endpackage

// File: rtl/regdst_scoreboard.sv
// Pending-write scoreboard: one bit per register (register 0 never tracked),
// set/clear arbitration with set priority, popcount tracking and RAW lookup.
module regdst_scoreboard #(
  parameter  int IDX_W = 5,
  localparam int NREGS = 1 << IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_en,
  input  logic [IDX_W-1:0] set_idx,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx,
  input  logic [IDX_W-1:0] rs_idx,
  input  logic [IDX_W-1:0] rt_idx,
  output logic [NREGS-1:0] pending,
  output logic [IDX_W:0]   pend_cnt,
  output logic             hazard,
  output logic             wb_miss
);
  logic [NREGS-1:0] pending_d, pending_q;
  logic [IDX_W:0]   cnt_d, cnt_q;
  logic             set_v, clr_v, net_set, net_clr;

  always_comb begin
    set_v   = set_en && (set_idx != '0);
    clr_v   = clr_en && (clr_idx != '0) && pending_q[clr_idx];
    wb_miss = clr_en && (clr_idx != '0) && !pending_q[clr_idx];
    // A clear of the index being set this cycle is swallowed by the set.
    net_set = set_v && !pending_q[set_idx];
    net_clr = clr_v && !(set_v && (set_idx == clr_idx));

    pending_d = pending_q;
    if (clr_v) pending_d[clr_idx] = 1'b0;
    if (set_v) pending_d[set_idx] = 1'b1;

    cnt_d = cnt_q;
    if (net_set && !net_clr)      cnt_d = cnt_q + 1'b1;
    else if (net_clr && !net_set) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  // Registered state only; a same-cycle writeback does not clear the hazard.
  assign hazard   = ((rs_idx != '0) && pending_q[rs_idx]) ||
                    ((rt_idx != '0) && pending_q[rt_idx]);
  assign pending  = pending_q;
  assign pend_cnt = cnt_q;
endmodule

// File: rtl/regdst_scoreboard_unit.sv
// Registered register-destination select with pending-write scoreboard:
// decodes the destination, gates allocation on WAW state, and tracks errors.
module regdst_scoreboard_unit
  import regdst_pkg::*;
#(
  parameter  int          IDX_W  = 5,
  parameter  int          SEL_W  = 3,
  parameter  int          SP_IDX = 29,
  parameter  int          RA_IDX = 31,
  localparam int          NREGS  = 1 << IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] data0,
  input  logic [IDX_W-1:0] data1,
  input  logic [IDX_W-1:0] data4,
  input  logic [IDX_W-1:0] data5,
  input  logic [SEL_W-1:0] RegDst,
  input  logic             issue_valid,
  output logic             issue_ready,
  output logic [IDX_W-1:0] dest_out,
  output logic             dest_valid,
  input  logic             wb_valid,
  input  logic [IDX_W-1:0] wb_idx,
  input  logic [IDX_W-1:0] rs_idx,
  input  logic [IDX_W-1:0] rt_idx,
  output logic             hazard,
  output logic [NREGS-1:0] pending,
  output logic [IDX_W:0]   pend_cnt,
  output logic [1:0]       err
);
  logic [IDX_W-1:0] sel_idx, dest_d, dest_q;
  logic             sel_ill, accept, dv_d, dv_q, wb_miss;
  logic [ERR_W-1:0] err_d, err_q;

  always_comb begin
    sel_ill = 1'b0;
    sel_idx = '0;
    case (RegDst)
      SEL_W'(SEL_RT): sel_idx = data0;
      SEL_W'(SEL_RD): sel_idx = data1;
      SEL_W'(SEL_SP): sel_idx = IDX_W'(SP_IDX);
      SEL_W'(SEL_RA): sel_idx = IDX_W'(RA_IDX);
      SEL_W'(SEL_X4): sel_idx = data4;
      SEL_W'(SEL_X5): sel_idx = data5;
      default:        sel_ill = 1'b1;
    endcase
  end

  // A writeback retiring the selected register this cycle frees it for reuse.
  assign issue_ready = (sel_idx == '0) || !pending[sel_idx] ||
                       (wb_valid && (wb_idx == sel_idx));
  assign accept      = issue_valid && issue_ready;

  always_comb begin
    dest_d = accept ? sel_idx : dest_q;
    dv_d   = accept;
    err_d  = err_q;
    if (issue_valid && sel_ill) err_d[ERR_ILL_SEL] = 1'b1;
    if (wb_miss)                err_d[ERR_WB_MISS] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dest_q <= '0;
      dv_q   <= 1'b0;
      err_q  <= '0;
    end else begin
      dest_q <= dest_d;
      dv_q   <= dv_d;
      err_q  <= err_d;
    end
  end

  regdst_scoreboard #(.IDX_W(IDX_W)) u_sb (
    .clk      (clk),
    .reset    (reset),
    .set_en   (accept),
    .set_idx  (sel_idx),
    .clr_en   (wb_valid),
    .clr_idx  (wb_idx),
    .rs_idx   (rs_idx),
    .rt_idx   (rt_idx),
    .pending  (pending),
    .pend_cnt (pend_cnt),
    .hazard   (hazard),
    .wb_miss  (wb_miss)
  );

  assign dest_out   = dest_q;
  assign dest_valid = dv_q;
  assign err        = err_q;
endmodule

// File: tb/tb_regdst_scoreboard_unit.sv
// Randomized + directed bench for regdst_scoreboard_unit against a
// set-of-pending-registers reference model.
module tb_regdst_scoreboard_unit;
  logic        clk, reset;
  logic [4:0]  data0, data1, data4, data5, wb_idx, rs_idx, rt_idx, dest_out;
  logic [2:0]  RegDst;
  logic        issue_valid, issue_ready, dest_valid, wb_valid, hazard;
  logic [31:0] pending;
  logic [5:0]  pend_cnt;
  logic [1:0]  err;

  int checks = 0, failures = 0;

  // reference model state
  bit   [31:0] m_pend;
  logic [4:0]  m_dout;
  bit          m_dv;
  bit   [1:0]  m_err;

  regdst_scoreboard_unit dut (
    .clk(clk), .reset(reset), .data0(data0), .data1(data1), .data4(data4),
    .data5(data5), .RegDst(RegDst), .issue_valid(issue_valid),
    .issue_ready(issue_ready), .dest_out(dest_out), .dest_valid(dest_valid),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .rs_idx(rs_idx), .rt_idx(rt_idx),
    .hazard(hazard), .pending(pending), .pend_cnt(pend_cnt), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_regs();
    chk("dest_out", 64'(dest_out), 64'(m_dout));
    chk("dest_valid", 64'(dest_valid), 64'(m_dv));
    chk("pending", 64'(pending), 64'(m_pend));
    chk("pend_cnt", 64'(pend_cnt), 64'($countones(m_pend)));
    chk("err", 64'(err), 64'(m_err));
  endtask

  task automatic model_reset();
    m_pend = '0; m_dout = '0; m_dv = 0; m_err = '0;
  endtask

  // Drive one cycle of inputs (called just after a falling edge), check
  // combinational outputs, advance the model and check registered outputs.
  task automatic step(input logic [4:0] d0, d1, d4, d5, input logic [2:0] rd,
                      input logic iv, input logic wv,
                      input logic [4:0] wi, rs, rt);
    logic [4:0] sel;
    bit rdy, hz, acc;
    data0 = d0; data1 = d1; data4 = d4; data5 = d5; RegDst = rd;
    issue_valid = iv; wb_valid = wv; wb_idx = wi; rs_idx = rs; rt_idx = rt;
    #1;
    case (rd)
      3'd0: sel = d0;
      3'd1: sel = d1;
      3'd2: sel = 5'd29;
      3'd3: sel = 5'd31;
      3'd4: sel = d4;
      3'd5: sel = d5;
      default: sel = 5'd0;
    endcase
    rdy = (sel == 0) || !m_pend[sel] || (wv && wi == sel);
    hz  = (rs != 0 && m_pend[rs]) || (rt != 0 && m_pend[rt]);
    chk("issue_ready", 64'(issue_ready), 64'(rdy));
    chk("hazard", 64'(hazard), 64'(hz));
    acc = iv && rdy;
    if (wv && wi != 0) begin
      if (m_pend[wi]) m_pend[wi] = 1'b0;
      else            m_err[1]   = 1'b1;
    end
    if (iv && rd > 3'd5) m_err[0] = 1'b1;
    if (acc) begin
      m_dout = sel;
      if (sel != 0) m_pend[sel] = 1'b1;
    end
    m_dv = acc;
    @(posedge clk); #1;
    check_regs();
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_regs();
    chk("hazard_rst", 64'(hazard), 64'(0));
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    data0 = '0; data1 = '0; data4 = '0; data5 = '0; RegDst = '0;
    issue_valid = 0; wb_valid = 0; wb_idx = '0; rs_idx = 5'd3; rt_idx = 5'd7;
    model_reset();
    #3;
    check_regs();
    chk("hazard_rst", 64'(hazard), 64'(0));
    @(negedge clk);
    reset = 1'b1;

    // $ra allocation
    step(0, 0, 0, 0, 3'd3, 1, 0, 0, 0, 0);
    // $sp pending: blocked, then accepted alongside its own writeback
    step(0, 0, 0, 0, 3'd2, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 3'd2, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 3'd2, 1, 1, 29, 0, 0);
    // RAW on data1 destination, cleared by writeback
    step(0, 8, 0, 0, 3'd1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 3'd0, 0, 0, 0, 8, 0);
    step(0, 0, 0, 0, 3'd0, 0, 1, 8, 8, 0);
    step(0, 0, 0, 0, 3'd0, 0, 0, 0, 8, 8);
    // illegal select, writeback miss, register-0 destination
    step(9, 9, 9, 9, 3'd7, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 3'd6, 0, 1, 5, 0, 0);
    step(0, 0, 0, 0, 3'd0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 400; n++) begin
      logic [4:0] r[7];
      bit wide;
      wide = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < 7; k++)
        r[k] = 5'(wide ? $urandom_range(0, 31) : $urandom_range(0, 7));
      step(r[0], r[1], r[2], r[3], 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r[4], r[5], r[6]);
    end

    async_reset();
    for (int i = 1; i < 32; i++)
      step(0, 0, 5'(i), 0, 3'd4, 1, 0, 0, 0, 0);
    chk("fill_cnt", 64'(pend_cnt), 64'(31));
    chk("dv_before_reset", 64'(dest_valid), 64'(1));
    // reset lands mid-cycle, while the last dest_valid pulse is still high
    reset = 1'b0;
    #1;
    model_reset();
    check_regs();
    @(negedge clk);
    reset = 1'b1;
    step(0, 0, 0, 0, 3'd3, 1, 0, 0, 31, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
